// File: rtl/imem_port_arbiter.sv
// Arbitrates the instruction SRAM RW port between the init loader (writes) and the fetch path (reads).
// Optional feature: define IMEM_ARB_RR_EN for round-robin conflict resolution instead of fixed priority.
module imem_port_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 32,
   parameter int MAX_WR_BURST = 4
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          wr_gnt,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_gnt,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          mem_csb,
   output logic          mem_web,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          busy
);

`ifdef IMEM_ARB_RR_EN
   localparam logic WINNER_RD = 1'b0;
   localparam logic WINNER_WR = 1'b1;

   logic last_winner_q;
   logic last_winner_d;
`else
   localparam int          CW        = $clog2(MAX_WR_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_WR_BURST);

   logic [CW-1:0] wr_burst_cnt_q;
   logic [CW-1:0] wr_burst_cnt_d;
`endif

   logic          rd_valid_q;
   logic          rd_valid_d;
   logic [DW-1:0] rd_hold_q;
   logic [DW-1:0] rd_hold_d;
   logic [AW-1:0] mem_addr_q;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_din_q;
   logic [DW-1:0] mem_din_d;
   logic          busy_q;
   logic          busy_d;

   // Grant decision: reset blocks everything, conflicts resolved by the selected policy
   always_comb begin
      wr_gnt = 1'b0;
      rd_gnt = 1'b0;
      if (reset) begin
         wr_gnt = 1'b0;
         rd_gnt = 1'b0;
      end else if (wr_req && rd_req) begin
`ifdef IMEM_ARB_RR_EN
         if (last_winner_q == WINNER_RD) begin
            wr_gnt = 1'b1;
         end else begin
            rd_gnt = 1'b1;
         end
`else
         if (wr_burst_cnt_q == BURST_MAX) begin
            rd_gnt = 1'b1;
         end else begin
            wr_gnt = 1'b1;
         end
`endif
      end else begin
         wr_gnt = wr_req;
         rd_gnt = rd_req;
      end
   end

   // Arbitration state update
   always_comb begin
`ifdef IMEM_ARB_RR_EN
      last_winner_d = last_winner_q;
      if (wr_req && rd_req && !reset) begin
         last_winner_d = wr_gnt ? WINNER_WR : WINNER_RD;
      end else begin
         last_winner_d = last_winner_q;
      end
`else
      // Count only writes that starve a pending read; anything else restarts the burst
      wr_burst_cnt_d = '0;
      if (wr_gnt && rd_req) begin
         if (wr_burst_cnt_q == BURST_MAX) begin
            wr_burst_cnt_d = wr_burst_cnt_q;
         end else begin
            wr_burst_cnt_d = wr_burst_cnt_q + CW'(1);
         end
      end else begin
         wr_burst_cnt_d = '0;
      end
`endif
   end

   // SRAM port drive, read-return pipeline and busy flag
   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      if (reset) begin
         mem_addr_d = '0;
         mem_din_d  = '0;
      end else if (wr_gnt) begin
         mem_addr_d = wr_addr;
         mem_din_d  = wr_data;
      end else if (rd_gnt) begin
         mem_addr_d = rd_addr;
         mem_din_d  = '0;
      end else begin
         mem_addr_d = mem_addr_q;
         mem_din_d  = mem_din_q;
      end

      rd_valid_d = rd_gnt;
      busy_d     = wr_gnt;
      // SRAM output is only meaningful in the cycle after the read; keep it afterwards
      if (rd_valid_q) begin
         rd_hold_d = mem_dout;
      end else begin
         rd_hold_d = rd_hold_q;
      end

      mem_csb  = ~(wr_gnt | rd_gnt);
      mem_web  = ~wr_gnt;
      mem_addr = mem_addr_d;
      mem_din  = mem_din_d;
      rd_valid = rd_valid_q;
      rd_data  = rd_valid_q ? mem_dout : rd_hold_q;
      busy     = busy_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (reset) begin
`ifdef IMEM_ARB_RR_EN
         last_winner_q  <= WINNER_RD;
`else
         wr_burst_cnt_q <= '0;
`endif
         rd_valid_q     <= 1'b0;
         rd_hold_q      <= '0;
         mem_addr_q     <= '0;
         mem_din_q      <= '0;
         busy_q         <= 1'b0;
      end else begin
`ifdef IMEM_ARB_RR_EN
         last_winner_q  <= last_winner_d;
`else
         wr_burst_cnt_q <= wr_burst_cnt_d;
`endif
         rd_valid_q     <= rd_valid_d;
         rd_hold_q      <= rd_hold_d;
         mem_addr_q     <= mem_addr_d;
         mem_din_q      <= mem_din_d;
         busy_q         <= busy_d;
      end
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: SRAM model, read-data scoreboard and scenario tasks.
module tb_imem_port_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   logic          reset;
   logic          wr_req, rd_req;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data;
   logic          wr_gnt, rd_gnt, rd_valid, mem_csb, mem_web, busy;
   logic [DW-1:0] rd_data, mem_din, mem_dout;
   logic [AW-1:0] mem_addr;

   logic [DW-1:0] sram      [0:255];
   logic [DW-1:0] model_mem [0:255];
   logic [DW-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;

   imem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WR_BURST(4)) dut (
      .CLK(CLK), .reset(reset),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Synchronous single-port SRAM: write or read on the rising edge
   always @(posedge CLK) begin
      if (!mem_csb) begin
         if (!mem_web) sram[mem_addr] <= mem_din;
         else          mem_dout <= sram[mem_addr];
      end
   end

   // Scoreboard: pop on rd_valid, push expected data on rd_gnt, check port drive on every grant
   always @(negedge CLK) begin
      if (rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_valid: rd_valid=1 with no outstanding read");
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL sb_rd_data: got %h expected %h", rd_data, e);
            end
         end
      end
      if (wr_gnt || rd_gnt) begin
         checks++;
         if (wr_gnt && rd_gnt) begin
            errors++;
            $display("FAIL both_grants: wr_gnt=1 rd_gnt=1 expected at most one");
         end else if (wr_gnt) begin
            if (mem_csb !== 1'b0 || mem_web !== 1'b0 || mem_addr !== wr_addr || mem_din !== wr_data) begin
               errors++;
               $display("FAIL wr_port: csb=%b web=%b addr=%h din=%h expected 0 0 %h %h",
                        mem_csb, mem_web, mem_addr, mem_din, wr_addr, wr_data);
            end
            model_mem[wr_addr] = wr_data;
         end else begin
            if (mem_csb !== 1'b0 || mem_web !== 1'b1 || mem_addr !== rd_addr || mem_din !== 32'h0) begin
               errors++;
               $display("FAIL rd_port: csb=%b web=%b addr=%h din=%h expected 0 1 %h 0",
                        mem_csb, mem_web, mem_addr, mem_din, rd_addr);
            end
            exp_q.push_back(model_mem[rd_addr]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      wr_addr = 8'h05; rd_addr = 8'h06; wr_data = 32'h1111_2222;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         checks++;
         if (wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || mem_csb !== 1'b1 || mem_web !== 1'b1) begin
            errors++;
            $display("FAIL reset_grants: wr_gnt=%b rd_gnt=%b csb=%b web=%b expected 0 0 1 1",
                     wr_gnt, rd_gnt, mem_csb, mem_web);
         end
         if (c == 1) begin
            checks++;
            if (rd_valid !== 1'b0 || rd_data !== 32'h0 || busy !== 1'b0 || mem_addr !== 8'h00 || mem_din !== 32'h0) begin
               errors++;
               $display("FAIL reset_state: rd_valid=%b rd_data=%h busy=%b addr=%h din=%h expected all 0",
                        rd_valid, rd_data, busy, mem_addr, mem_din);
            end
         end
         @(posedge CLK); #1;
      end
      reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit got = 1'b0;
      wr_addr = a; wr_data = d; wr_req = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge CLK);
         if (wr_gnt === 1'b1) got = 1'b1;
         @(posedge CLK); #1;
      end
      wr_req = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL write_timeout: no wr_gnt for addr %h within 20 cycles", a);
      end
   endtask

   task automatic test_write_read();
      do_write(8'h10, 32'hDEAD_BEEF);
      rd_addr = 8'h10; rd_req = 1'b1;
      @(negedge CLK);
      checks++;
      if (busy !== 1'b1 || rd_gnt !== 1'b1) begin
         errors++;
         $display("FAIL wr_rd_grant: busy=%b rd_gnt=%b expected 1 1", busy, rd_gnt);
      end
      @(posedge CLK); #1;
      rd_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF || busy !== 1'b0) begin
         errors++;
         $display("FAIL wr_rd_data: rd_valid=%b rd_data=%h busy=%b expected 1 deadbeef 0",
                  rd_valid, rd_data, busy);
      end
      @(posedge CLK); #1;
      @(negedge CLK);
      checks++;
      if (mem_csb !== 1'b1 || mem_addr !== 8'h10 || rd_valid !== 1'b0 || rd_data !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL idle_hold: csb=%b addr=%h rd_valid=%b rd_data=%h expected 1 10 0 deadbeef",
                  mem_csb, mem_addr, rd_valid, rd_data);
      end
      @(posedge CLK); #1;
   endtask

`ifndef IMEM_ARB_RR_EN
   task automatic test_burst_limit();
      bit exp_w;
      bit prev_rd = 1'b0;
      wr_addr = 8'h40; wr_data = 32'hA5A5_0000; rd_addr = 8'h40;
      wr_req = 1'b1; rd_req = 1'b1;
      for (int c = 0; c < 15; c++) begin
         exp_w = ((c % 5) != 4);
         @(negedge CLK);
         checks++;
         if (wr_gnt !== exp_w || rd_gnt !== !exp_w || rd_valid !== prev_rd) begin
            errors++;
            $display("FAIL burst_c%0d: wr_gnt=%b rd_gnt=%b rd_valid=%b expected %b %b %b",
                     c, wr_gnt, rd_gnt, rd_valid, exp_w, !exp_w, prev_rd);
         end
         prev_rd = !exp_w;
         @(posedge CLK); #1;
         if (exp_w) wr_data = wr_data + 32'd1;
      end
      wr_req = 1'b0; rd_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'hA5A5_000B) begin
         errors++;
         $display("FAIL burst_last_read: rd_valid=%b rd_data=%h expected 1 a5a5000b", rd_valid, rd_data);
      end
      @(posedge CLK); #1;
   endtask
`else
   task automatic test_round_robin();
      bit exp_w;
      apply_reset();
      wr_addr = 8'h50; wr_data = 32'h0BAD_F00D; rd_addr = 8'h51;
      wr_req = 1'b1; rd_req = 1'b1;
      for (int c = 0; c < 6; c++) begin
         exp_w = ((c % 2) == 0);
         @(negedge CLK);
         checks++;
         if (wr_gnt !== exp_w || rd_gnt !== !exp_w) begin
            errors++;
            $display("FAIL rr_c%0d: wr_gnt=%b rd_gnt=%b expected %b %b", c, wr_gnt, rd_gnt, exp_w, !exp_w);
         end
         @(posedge CLK); #1;
      end
      wr_req = 1'b0; rd_req = 1'b0;
      @(posedge CLK); #1;
   endtask
`endif

   task automatic test_same_addr();
      apply_reset();
      wr_addr = 8'h20; wr_data = 32'h0000_1234; rd_addr = 8'h20;
      wr_req = 1'b1; rd_req = 1'b1;
      @(negedge CLK);
      checks++;
      if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0) begin
         errors++;
         $display("FAIL same_addr_first: wr_gnt=%b rd_gnt=%b expected 1 0", wr_gnt, rd_gnt);
      end
      @(posedge CLK); #1;
      wr_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (rd_gnt !== 1'b1) begin
         errors++;
         $display("FAIL same_addr_read_gnt: rd_gnt=%b expected 1", rd_gnt);
      end
      @(posedge CLK); #1;
      rd_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h0000_1234) begin
         errors++;
         $display("FAIL same_addr_data: rd_valid=%b rd_data=%h expected 1 00001234", rd_valid, rd_data);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_mid_read();
      rd_addr = 8'h10; rd_req = 1'b1; reset = 1'b1;
      @(negedge CLK);
      checks++;
      if (rd_gnt !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_gnt: rd_gnt=%b expected 0", rd_gnt);
      end
      @(posedge CLK); #1;
      reset = 1'b0; rd_req = 1'b0;
      @(negedge CLK);
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_valid: rd_valid=%b expected 0", rd_valid);
      end
      rd_req = 1'b1;
      @(negedge CLK);
      checks++;
      if (rd_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_regrant: rd_gnt=%b expected 1", rd_gnt);
      end
      @(posedge CLK); #1;
      rd_req = 1'b0; reset = 1'b1;
      @(posedge CLK); #1;
      reset = 1'b0;
      @(negedge CLK);
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_clear: rd_valid=%b rd_data=%h busy=%b expected 0 0 0",
                  rd_valid, rd_data, busy);
      end
      @(posedge CLK); #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         sram[i] = 32'h0;
         model_mem[i] = 32'h0;
      end
      mem_dout = 32'h0;
      reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
      wr_addr = 8'h00; rd_addr = 8'h00; wr_data = 32'h0;
      #1;
      test_reset();
      test_write_read();
`ifndef IMEM_ARB_RR_EN
      test_burst_limit();
`else
      test_round_robin();
`endif
      test_same_addr();
      test_reset_mid_read();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d reads outstanding, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
